// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down hex counter and its display decoder.
package counter_pkg;

   typedef enum logic [1:0] {
      WRAP      = 2'b00,
      SATURATE  = 2'b01,
      RELOAD    = 2'b10,
      MODE_RSVD = 2'b11
   } cnt_mode_t;

   // Entry n is the active-high dp,gfedcba pattern for hex digit n.
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment decoder, decimal point always off.
module hex7seg
   import counter_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [7:0] seg_o
);

   assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/updown_counter_hex.sv
// Up/down counter with load, enable, selectable boundary mode, terminal-count pulse
// and a registered multi-digit hex 7-segment display.
module updown_counter_hex
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = 2**WIDTH - 1,
   parameter int unsigned NDIGITS = (WIDTH + 3) / 4
) (
   input  logic                   clk_2,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   up,
   input  logic                   load,
   input  logic [WIDTH-1:0]       load_val,
   input  logic [1:0]             mode,
   output logic [WIDTH-1:0]       count,
   output logic                   tc,
   output logic [8*NDIGITS-1:0]   seg
);

   localparam logic [WIDTH-1:0] MaxV  = WIDTH'(MAX_VAL);
   localparam int unsigned      NBits = 4 * NDIGITS;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] disp_q;
   logic [WIDTH-1:0] clamp_val;
   logic [WIDTH-1:0] bound_val;
   logic             at_bound;
   logic [NBits-1:0] disp_ext;
   cnt_mode_t        mode_e;

   assign mode_e    = cnt_mode_t'(mode);
   assign clamp_val = (load_val > MaxV) ? MaxV : load_val;
   assign at_bound  = up ? (count_q == MaxV) : (count_q == '0);

   // Value taken when a step would leave the 0..MAX_VAL range.
   always_comb begin
      bound_val = up ? '0 : MaxV;
      case (mode_e)
         SATURATE: bound_val = count_q;
         RELOAD:   bound_val = clamp_val;
         default:  bound_val = up ? '0 : MaxV;
      endcase
   end

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = clamp_val;
      end else if (en) begin
         if (at_bound) begin
            count_d = bound_val;
            tc_d    = 1'b1;
         end else if (up) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         disp_q  <= '0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         disp_q  <= count_q;
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign disp_ext = NBits'(disp_q);

   for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
      hex7seg u_hex7seg (
         .hex_i (disp_ext[4*k +: 4]),
         .seg_o (seg[8*k +: 8])
      );
   end

endmodule
